// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_t   : FSM state with its fixed 3-bit encoding (visible on STATE)
//   LOSS_CNT_W    : width of the lock-loss event counter
//   LOSS_CNT_MAX  : saturation value of the lock-loss event counter
//   loss_cnt_inc  : saturating increment for the lock-loss counter
package reset_seq_pkg;

    typedef enum logic [2:0] {
        IDLE_RST  = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SW_HOLD   = 3'd4
    } seq_state_t;

    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

    // Increment that sticks at LOSS_CNT_MAX instead of wrapping to zero.
    function automatic logic [LOSS_CNT_W-1:0] loss_cnt_inc(input logic [LOSS_CNT_W-1:0] cnt);
        logic [LOSS_CNT_W-1:0] result;
        if (cnt == LOSS_CNT_MAX) begin
            result = cnt;
        end else begin
            result = cnt + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into
// the CLK domain. Both flops clear to 0 on the synchronous reset, so the
// lock is seen as absent until two clean samples have passed through.
//   clk      in  : sampling clock
//   rst      in  : synchronous active-high reset
//   async_in in  : asynchronous lock pin
//   sync_out out : synchronized lock, 2 cycles of latency
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Synchronizer chain; the first flop may go metastable, the second is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// Sequences per-domain fabric resets behind CoreRESET_PF. After
// FABRIC_RESET_N is high and a filtered PLL lock is stable, domains are
// released in index order, STAGE_DELAY cycles apart. Lock loss forces a full
// re-sequence; software requests pulse a domain and all higher domains.
//   CLK            in  : single clock
//   RST            in  : synchronous active-high reset
//   FABRIC_RESET_N in  : upstream reset, low forces every domain into reset
//   PLL_LOCK       in  : asynchronous PLL lock, synchronized internally
//   SW_RST_REQ     in  : one-cycle per-domain software reset requests
//   DOMAIN_RST_N   out : registered active-low domain resets
//   ALL_READY      out : high only in RUN
//   STATE          out : current FSM state encoding
//   LOCK_LOSS_CNT  out : saturating count of lock-loss events
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 4,
    parameter int STAGE_DELAY     = 16,
    parameter int LOCK_FILTER     = 8,
    parameter int SW_PULSE_CYCLES = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FABRIC_RESET_N,
    input  logic                   PLL_LOCK,
    input  logic [NUM_DOMAINS-1:0] SW_RST_REQ,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
    output logic                   ALL_READY,
    output logic [2:0]             STATE,
    output logic [LOSS_CNT_W-1:0]  LOCK_LOSS_CNT
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int DLY_W  = $clog2(STAGE_DELAY);
    localparam int HOLD_W = $clog2(SW_PULSE_CYCLES + 1);
    localparam int IDX_W  = $clog2(NUM_DOMAINS);

    localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(LOCK_FILTER - 1);
    localparam logic [DLY_W-1:0]  DLY_RELOAD  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(SW_PULSE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

    seq_state_t                 state_r, state_s;
    logic [FILT_W-1:0]          filt_r, filt_s;
    logic [DLY_W-1:0]           dly_r, dly_s;
    logic [HOLD_W-1:0]          hold_r, hold_s;
    logic [IDX_W-1:0]           idx_r, idx_s;
    logic [LOSS_CNT_W-1:0]      loss_r, loss_s;
    logic [NUM_DOMAINS-1:0]     dom_r, dom_s;
    logic                       ready_r, ready_s;

    logic                       lock_sync_s;
    logic                       lock_lost_s;
    logic [IDX_W-1:0]           sw_low_s;
    logic [NUM_DOMAINS-1:0]     sw_mask_s;

    pll_lock_sync u_lock_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (PLL_LOCK),
        .sync_out (lock_sync_s)
    );

    // Loss only counts once the sequence has started; WAIT_LOCK/IDLE_RST ignore it.
    assign lock_lost_s = ((state_r == RELEASE) || (state_r == RUN) || (state_r == SW_HOLD))
                         && !lock_sync_s;

    // Lowest requested domain, and the reset mask covering it plus every higher
    // domain, since higher domains depend on the lower ones.
    always_comb begin
        sw_low_s  = {IDX_W{1'b0}};
        sw_mask_s = {NUM_DOMAINS{1'b0}};
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            sw_low_s = SW_RST_REQ[i] ? IDX_W'(i) : sw_low_s;
        end
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            sw_mask_s[i] = (IDX_W'(i) >= sw_low_s);
        end
    end

    // Next-state, counter and output computation in event-priority order.
    always_comb begin
        state_s = state_r;
        filt_s  = filt_r;
        dly_s   = dly_r;
        hold_s  = hold_r;
        idx_s   = idx_r;
        loss_s  = loss_r;
        dom_s   = dom_r;
        ready_s = ready_r;

        if (!FABRIC_RESET_N) begin
            state_s = IDLE_RST;
            filt_s  = {FILT_W{1'b0}};
            dom_s   = {NUM_DOMAINS{1'b0}};
            ready_s = 1'b0;
        end else if (lock_lost_s) begin
            state_s = WAIT_LOCK;
            filt_s  = {FILT_W{1'b0}};
            dom_s   = {NUM_DOMAINS{1'b0}};
            ready_s = 1'b0;
            loss_s  = loss_cnt_inc(loss_r);
        end else begin
            case (state_r)
                IDLE_RST: begin
                    state_s = WAIT_LOCK;
                    filt_s  = {FILT_W{1'b0}};
                end
                WAIT_LOCK: begin
                    if (!lock_sync_s) begin
                        filt_s = {FILT_W{1'b0}};
                    end else if (filt_r == FILT_LAST) begin
                        state_s = RELEASE;
                        filt_s  = {FILT_W{1'b0}};
                        idx_s   = {IDX_W{1'b0}};
                        dly_s   = DLY_RELOAD;
                    end else begin
                        filt_s = filt_r + 1'b1;
                    end
                end
                RELEASE: begin
                    filt_s = {FILT_W{1'b0}};
                    if (dly_r == {DLY_W{1'b0}}) begin
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            dom_s[i] = (IDX_W'(i) == idx_r) ? 1'b1 : dom_r[i];
                        end
                        if (idx_r == IDX_LAST) begin
                            state_s = RUN;
                            ready_s = 1'b1;
                        end else begin
                            idx_s = idx_r + 1'b1;
                            dly_s = DLY_RELOAD;
                        end
                    end else begin
                        dly_s = dly_r - 1'b1;
                    end
                end
                RUN: begin
                    filt_s = {FILT_W{1'b0}};
                    if (SW_RST_REQ != {NUM_DOMAINS{1'b0}}) begin
                        state_s = SW_HOLD;
                        dom_s   = dom_r & ~sw_mask_s;
                        ready_s = 1'b0;
                        idx_s   = sw_low_s;
                        hold_s  = HOLD_RELOAD;
                    end else begin
                        state_s = RUN;
                    end
                end
                SW_HOLD: begin
                    filt_s = {FILT_W{1'b0}};
                    if (hold_r == {HOLD_W{1'b0}}) begin
                        state_s = RELEASE;
                        dly_s   = DLY_RELOAD;
                    end else begin
                        hold_s = hold_r - 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE_RST;
                    filt_s  = {FILT_W{1'b0}};
                    dom_s   = {NUM_DOMAINS{1'b0}};
                    ready_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers; RST restores every power-up value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE_RST;
            filt_r  <= {FILT_W{1'b0}};
            dly_r   <= {DLY_W{1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            loss_r  <= {LOSS_CNT_W{1'b0}};
            dom_r   <= {NUM_DOMAINS{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            filt_r  <= filt_s;
            dly_r   <= dly_s;
            hold_r  <= hold_s;
            idx_r   <= idx_s;
            loss_r  <= loss_s;
            dom_r   <= dom_s;
            ready_r <= ready_s;
        end
    end

    assign DOMAIN_RST_N  = dom_r;
    assign ALL_READY     = ready_r;
    assign STATE         = state_r;
    assign LOCK_LOSS_CNT = loss_r;

endmodule
